// File: rtl/sr_bank_driver.sv
// Write-side controller for a bank of clocked SR flops: encodes S/R from the
// target word and Q feedback, pulses them for one cycle, then verifies Q.
module sr_bank_driver #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  input  logic             tgt_force,
  output logic             tgt_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    s_d     = s_q;
    r_d     = r_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (tgt_valid && ready_q) begin
          tgt_d = tgt_data;
          // Forced writes excite every bit; otherwise matching bits are held.
          if (tgt_force) begin
            s_d = tgt_data;
            r_d = ~tgt_data;
          end else begin
            s_d = tgt_data & ~q_fb;
            r_d = ~tgt_data & q_fb;
          end
          mask_d  = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        s_d     = '0;
        r_d     = '0;
        cnt_d   = 8'(SETTLE_CYCLES - 1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (cnt_q == 8'd0) state_d = CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      CHECK: begin
        mask_d  = q_fb ^ tgt_q;
        err_d   = |(q_fb ^ tgt_q);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      s_q     <= '0;
      r_q     <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      s_q     <= s_d;
      r_q     <= r_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign tgt_ready = ready_q;
  assign s_out     = s_q;
  assign r_out     = r_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = mask_q;

endmodule

// File: tb/tb_sr_bank_driver.sv
// Bench for sr_bank_driver: SR flop bank models, a transaction-age reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_sr_bank_driver;

  localparam int W  = 8;
  localparam int S1 = 1;
  localparam int S3 = 3;

  logic         clk;
  logic         rst_n;

  // Instance with SETTLE_CYCLES = 1
  logic         tgt_valid, tgt_force;
  logic [W-1:0] tgt_data, q_fb, stuck0;
  logic         tgt_ready, busy, done, err;
  logic [W-1:0] s_out, r_out, err_mask;
  logic [W-1:0] bank_q = 8'h00;

  // Instance with SETTLE_CYCLES = 3
  logic         v3, f3;
  logic [W-1:0] d3, q3;
  logic         ready3, busy3, done3, err3;
  logic [W-1:0] s3, r3, mask3;
  logic [W-1:0] bank3_q = 8'h00;

  int checks = 0;
  int errors = 0;

  sr_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(S1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_force(tgt_force),
    .tgt_ready(tgt_ready), .s_out(s_out), .r_out(r_out), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err), .err_mask(err_mask)
  );

  sr_bank_driver #(.WIDTH(W), .SETTLE_CYCLES(S3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .tgt_valid(v3), .tgt_data(d3), .tgt_force(f3),
    .tgt_ready(ready3), .s_out(s3), .r_out(r3), .q_fb(q3),
    .busy(busy3), .done(done3), .err(err3), .err_mask(mask3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SR flop banks: S sets, R clears, neither holds.
  always @(posedge clk) bank_q  <= (bank_q | s_out) & ~r_out;
  always @(posedge clk) bank3_q <= (bank3_q | s3) & ~r3;
  assign q_fb = bank_q & ~stuck0;
  assign q3   = bank3_q;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks edges elapsed since the accept of the in-flight write.
  bit           m_active;
  int           m_age;
  logic         m_ready, m_done, m_err;
  logic [W-1:0] m_tgt, m_s, m_r, m_mask;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 0; m_age <= 0; m_ready <= 0; m_done <= 0; m_err <= 0;
      m_tgt <= '0; m_s <= '0; m_r <= '0; m_mask <= '0;
    end else begin
      m_done <= 0;
      m_err  <= 0;
      if (m_active) begin
        m_age <= m_age + 1;
        if (m_age + 1 == 1) begin
          m_s <= '0;
          m_r <= '0;
        end
        if (m_age + 1 == 2 + S1) begin
          m_active <= 0;
          m_done   <= 1;
          m_err    <= ((q_fb ^ m_tgt) != 0);
          m_mask   <= q_fb ^ m_tgt;
          m_ready  <= 1;
        end
      end else if (m_ready && tgt_valid) begin
        m_active <= 1;
        m_age    <= 0;
        m_tgt    <= tgt_data;
        m_s      <= tgt_force ? tgt_data  : (tgt_data & ~q_fb);
        m_r      <= tgt_force ? ~tgt_data : (~tgt_data & q_fb);
        m_mask   <= '0;
        m_ready  <= 0;
      end else begin
        m_ready <= 1;
      end
    end
  end

  always @(negedge clk) begin
    check("ready",    tgt_ready, m_ready);
    check("s_out",    s_out,     m_s);
    check("r_out",    r_out,     m_r);
    check("busy",     busy,      m_active);
    check("done",     done,      m_done);
    check("err",      err,       m_err);
    check("err_mask", err_mask,  m_mask);
    check("s_and_r",  s_out & r_out, 0);
    check("s_and_r3", s3 & r3,       0);
  end

  task automatic write1(input logic [W-1:0] d, input logic f, output int lat,
                        output logic [W-1:0] s1, output logic [W-1:0] r1,
                        output logic [W-1:0] m1, output logic e, output logic [W-1:0] m);
    @(negedge clk);
    tgt_valid = 1'b1; tgt_data = d; tgt_force = f;
    @(negedge clk);
    tgt_valid = 1'b0;
    lat = 1; s1 = s_out; r1 = r_out; m1 = err_mask;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    e = err; m = err_mask;
  endtask

  int           lat, a2, low;
  logic [W-1:0] s1, r1, m1, m;
  logic         e, d_at_acc;

  initial begin
    rst_n = 1'b1; tgt_valid = 0; tgt_data = '0; tgt_force = 0; stuck0 = '0;
    v3 = 0; d3 = '0; f3 = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", tgt_ready, 0);
    check("rst_sr", {s_out, r_out}, 0);
    check("rst_flags", {busy, done, err, err_mask}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", tgt_ready, 1);

    // Reset in the middle of DRIVE
    @(negedge clk);
    tgt_valid = 1'b1; tgt_data = 8'hFF; tgt_force = 1'b1;
    @(posedge clk);
    #1;
    tgt_valid = 1'b0;
    check("drive_s", s_out, 8'hFF);
    check("drive_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_s", s_out, 8'h00);
    check("async_r", r_out, 8'h00);
    check("async_busy", busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_done_in_rst", done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst2", tgt_ready, 1);
    check("no_done_after_rst", done, 0);

    // Force write of 0x00
    write1(8'h00, 1'b1, lat, s1, r1, m1, e, m);
    check("force_s", s1, 8'h00);
    check("force_r", r1, 8'hFF);
    check("force_lat", lat, 4);
    check("force_err", e, 0);
    check("force_mask", m, 8'h00);

    // Excitation: bank 0x0F -> 0x3C
    write1(8'h0F, 1'b1, lat, s1, r1, m1, e, m);
    check("preload_0f", bank_q, 8'h0F);
    write1(8'h3C, 1'b0, lat, s1, r1, m1, e, m);
    check("exc_s", s1, 8'h30);
    check("exc_r", r1, 8'h03);
    check("exc_lat", lat, 4);
    check("exc_err", e, 0);
    check("exc_bank", bank_q, 8'h3C);

    // Hold: bank already matches
    write1(8'hA5, 1'b1, lat, s1, r1, m1, e, m);
    write1(8'hA5, 1'b0, lat, s1, r1, m1, e, m);
    check("hold_s", s1, 8'h00);
    check("hold_r", r1, 8'h00);
    check("hold_lat", lat, 4);
    check("hold_err", e, 0);

    // Readback fault: bit 2 stuck at 0
    stuck0 = 8'h04;
    write1(8'hFF, 1'b1, lat, s1, r1, m1, e, m);
    check("fault_lat", lat, 4);
    check("fault_err", e, 1);
    check("fault_mask", m, 8'h04);
    repeat (4) @(negedge clk);
    check("fault_mask_held", err_mask, 8'h04);
    stuck0 = 8'h00;
    write1(8'h5A, 1'b1, lat, s1, r1, m1, e, m);
    check("mask_cleared_on_accept", m1, 8'h00);
    check("clean_err", e, 0);

    // Back-to-back on the SETTLE_CYCLES=3 instance
    @(negedge clk);
    check("b2b_ready0", ready3, 1);
    v3 = 1'b1; d3 = 8'h11; f3 = 1'b1;
    a2 = -1; low = 0; d_at_acc = 1'b0;
    for (int n = 1; n < 40 && a2 < 0; n++) begin
      @(negedge clk);
      if (n == 1) begin
        d3 = 8'h22;
        check("b2b_busy", busy3, 1);
      end
      if (ready3) begin
        a2 = n;
        d_at_acc = done3;
      end else begin
        low++;
      end
    end
    check("b2b_gap", a2, 6);
    check("b2b_ready_low", low, 5);
    check("b2b_done_at_accept", d_at_acc, 1);
    check("b2b_first_bank", bank3_q, 8'h11);
    @(negedge clk);
    v3 = 1'b0;
    lat = 1;
    while (!done3 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat2", lat, 6);
    check("b2b_err2", err3, 0);
    check("b2b_mask2", mask3, 8'h00);
    check("b2b_bank", bank3_q, 8'h22);
    @(negedge clk);
    check("b2b_done_pulse", done3, 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
